i2c_arbiter: RTL

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter granting one of N_REQ requesters access to a shared I2C engine.
// Optional WAIT watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   req_mode,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     err,
    output logic                 i2c_start,
    output logic [1:0]           i2c_mode,
    input  logic                 i2c_done,
    output logic                 busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SUM_W = IDX_W + 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("i2c_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [1:0]       mode_reg, mode_next;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timed_out_reg, timed_out_next;
`endif

    // Candidate gi is the requester gi positions after rr_ptr, wrapping at N_REQ.
    logic [IDX_W-1:0] cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        logic [SUM_W-1:0] sum;
        assign sum          = {1'b0, rr_ptr_reg} + SUM_W'(gi);
        assign cand_idx[gi] = (sum >= SUM_W'(N_REQ)) ? IDX_W'(sum - SUM_W'(N_REQ))
                                                     : sum[IDX_W-1:0];
        assign cand_hit[gi] = req[cand_idx[gi]];
    end

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx[i];
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        mode_next   = mode_reg;
        rr_ptr_next = rr_ptr_reg;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_next       = cnt_reg;
        timed_out_next = timed_out_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    idx_next   = pick_idx;
                    mode_next  = req_mode[{pick_idx, 1'b0} +: 2];
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                cnt_next       = '0;
                timed_out_next = 1'b0;
`endif
            end
            WAIT: begin
                if (i2c_done) begin
                    state_next = RELEASE;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                // Last allowed WAIT cycle: the count reaches TIMEOUT_CYCLES on this edge.
                else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next     = RELEASE;
                    timed_out_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            RELEASE: begin
                rr_ptr_next = (idx_reg == IDX_W'(N_REQ - 1)) ? '0 : idx_reg + 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            rr_ptr_reg <= '0;
            mode_reg   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_reg       <= '0;
            timed_out_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            rr_ptr_reg <= rr_ptr_next;
            mode_reg   <= mode_next;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_reg       <= cnt_next;
            timed_out_reg <= timed_out_next;
`endif
        end
    end

    // All outputs decode registered state, so reset clears them without waiting for a clock.
    assign busy      = (state_reg != IDLE);
    assign i2c_start = (state_reg == ISSUE);
    assign i2c_mode  = mode_reg;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_out
        logic sel;
        assign sel     = (idx_reg == IDX_W'(gi));
        assign gnt[gi] = busy && sel;
`ifdef I2C_ARB_TIMEOUT_EN
        assign ack[gi] = (state_reg == RELEASE) && sel && !timed_out_reg;
        assign err[gi] = (state_reg == RELEASE) && sel && timed_out_reg;
`else
        assign ack[gi] = (state_reg == RELEASE) && sel;
        assign err[gi] = 1'b0;
`endif
    end

endmodule
